// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : 640x480@60 timing constants and RGB444 pixel layout.
// Revision: 1.0
// ============================================================================
package vga_pkg;

   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] H_FP     = 10'd16;
   localparam logic [9:0] H_SYNC   = 10'd96;
   localparam logic [9:0] H_TOTAL  = 10'd800;
   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam logic [9:0] V_FP     = 10'd10;
   localparam logic [9:0] V_SYNC   = 10'd2;
   localparam logic [9:0] V_TOTAL  = 10'd525;

   localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
   localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
   localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

   // Frame size shared with the layer controller
   localparam int SCREEN_WIDTH_DEF  = 320;
   localparam int SCREEN_HEIGHT_DEF = 180;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// vga_timing : pixel-strobe driven h/v counters with stage-0 sync/active flags.
// Revision: 1.0
// ============================================================================
module vga_timing
   import vga_pkg::*;
(
   input  logic       CLK,
   input  logic       rst,
   input  logic       pix_stb,
   output logic [9:0] h_cnt_o,
   output logic [9:0] v_cnt_o,
   output logic [9:0] h_nxt_o,
   output logic [9:0] v_nxt_o,
   output logic       hs_o,
   output logic       vs_o,
   output logic       active_o,
   output logic       screenend_o
);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;

   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_TOTAL - 10'd1) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_TOTAL - 10'd1) ? '0 : v_cnt_q + 10'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else if (pix_stb) begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Next-pixel coordinates let the address register run one pixel ahead
   assign h_nxt_o     = h_cnt_d;
   assign v_nxt_o     = v_cnt_d;
   assign h_cnt_o     = h_cnt_q;
   assign v_cnt_o     = v_cnt_q;
   assign hs_o        = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
   assign vs_o        = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
   assign active_o    = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
   assign screenend_o = (h_cnt_q == H_ACTIVE - 10'd1) && (v_cnt_q == V_ACTIVE - 10'd1);

endmodule
`default_nettype wire

// File: rtl/vram_scanout.sv
`default_nettype none
// ============================================================================
// vram_scanout : VGA scanout of a 2x-upscaled, letterboxed frame held in VRAM.
// Revision: 1.0
// ============================================================================
module vram_scanout
   import vga_pkg::*;
#(
   parameter int          VRAM_A_WIDTH   = 16,
   parameter int          PIX_DATA_WIDTH = 12,
   parameter int          SCREEN_WIDTH   = SCREEN_WIDTH_DEF,
   parameter int          SCREEN_HEIGHT  = SCREEN_HEIGHT_DEF,
   parameter int          V_OFFSET       = 60,
   parameter logic [11:0] BORDER_COLOR   = 12'h000
) (
   input  logic                      CLK,
   input  logic                      rst,
   input  logic                      pix_stb,
   input  logic [PIX_DATA_WIDTH-1:0] i_vram_data,
   output logic [VRAM_A_WIDTH-1:0]   o_address_vram,
   output logic                      o_hs,
   output logic                      o_vs,
   output logic                      o_blank,
   output logic [3:0]                o_r,
   output logic [3:0]                o_g,
   output logic [3:0]                o_b,
   output logic                      o_screenend
);

   localparam logic [9:0] C_WIN_V_LO  = 10'(V_OFFSET);
   localparam logic [9:0] C_WIN_V_HI  = 10'(V_OFFSET + 2 * SCREEN_HEIGHT);
   localparam logic [9:0] C_LAST_LINE = 10'(V_OFFSET + 2 * SCREEN_HEIGHT - 1);
   localparam logic [9:0] C_PRE_LINE  = 10'(V_OFFSET - 1);
   localparam logic [9:0] C_WIN_H     = 10'(2 * SCREEN_WIDTH);
   localparam logic       C_LO_PAR    = C_WIN_V_LO[0];
   localparam logic [VRAM_A_WIDTH-1:0] C_ROW_STEP = VRAM_A_WIDTH'(SCREEN_WIDTH);

   function automatic logic in_window(input logic [9:0] v, input logic [9:0] h);
      return (v >= C_WIN_V_LO) && (v < C_WIN_V_HI) && (h < C_WIN_H);
   endfunction

   logic [9:0]              w_h, w_v, w_h_nxt, w_v_nxt;
   logic                    w_hs0, w_vs0, w_active0, w_se0;
   logic                    w_win0, w_win_nxt, w_line_end, w_odd_line;
   logic [VRAM_A_WIDTH-1:0] w_col;
   logic [VRAM_A_WIDTH-1:0] row_base_q, row_base_d;
   logic [VRAM_A_WIDTH-1:0] addr_q, addr_d;
   logic                    hs_q, vs_q, blank_q;
   rgb444_t                 rgb_q, rgb_d;

   vga_timing u_timing (
      .CLK         (CLK),
      .rst         (rst),
      .pix_stb     (pix_stb),
      .h_cnt_o     (w_h),
      .v_cnt_o     (w_v),
      .h_nxt_o     (w_h_nxt),
      .v_nxt_o     (w_v_nxt),
      .hs_o        (w_hs0),
      .vs_o        (w_vs0),
      .active_o    (w_active0),
      .screenend_o (w_se0)
   );

   assign w_line_end = (w_h == H_TOTAL - 10'd1);
   assign w_win0     = in_window(w_v, w_h);
   assign w_win_nxt  = in_window(w_v_nxt, w_h_nxt);
   // Parity of (v - V_OFFSET) without a subtractor
   assign w_odd_line = w_v[0] ^ C_LO_PAR;
   assign w_col      = VRAM_A_WIDTH'(w_h_nxt >> 1);

   // The address is loaded with the pixel the counters step to, so the VRAM
   // word is ready when that pixel is consumed on the following strobe.
   always_comb begin
      row_base_d = row_base_q;
      if (pix_stb && w_line_end) begin
         if (w_v == C_PRE_LINE) begin
            row_base_d = '0;
         end else if ((w_v >= C_WIN_V_LO) && (w_v < C_LAST_LINE) && w_odd_line) begin
            row_base_d = row_base_q + C_ROW_STEP;
         end
      end
      addr_d = addr_q;
      if (pix_stb && w_win_nxt) begin
         addr_d = row_base_d + w_col;
      end
   end

   always_comb begin
      rgb_d = '0;
      if (w_active0) begin
         rgb_d = w_win0 ? rgb444_t'(i_vram_data) : rgb444_t'(BORDER_COLOR);
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         row_base_q <= '0;
         addr_q     <= '0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         blank_q    <= 1'b1;
         rgb_q      <= '0;
      end else begin
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         if (pix_stb) begin
            hs_q    <= w_hs0;
            vs_q    <= w_vs0;
            blank_q <= !w_active0;
            rgb_q   <= rgb_d;
         end
      end
   end

   assign o_address_vram = addr_q;
   assign o_hs           = hs_q;
   assign o_vs           = vs_q;
   assign o_blank        = blank_q;
   assign o_r            = rgb_q.r;
   assign o_g            = rgb_q.g;
   assign o_b            = rgb_q.b;
   assign o_screenend    = w_se0;

endmodule
`default_nettype wire

// File: tb/tb_vram_scanout.sv
`default_nettype none
// ============================================================================
// tb_vram_scanout : scoreboard bench for vram_scanout (PIX_DIV=4, VRAM data = addr[11:0]).
// Revision: 1.0
// ============================================================================
module tb_vram_scanout;

   localparam int          PIX_DIV = 4;
   localparam logic [11:0] BORDER  = 12'hA5C;

   logic        CLK = 1'b0;
   logic        rst = 1'b1;
   logic        pix_stb = 1'b0;
   logic [11:0] vram_data = '0;
   logic [15:0] addr;
   logic        hs, vs, blank, se;
   logic [3:0]  r, g, b;

   int total = 0;
   int bad   = 0;

   vram_scanout #(.BORDER_COLOR(BORDER)) dut (
      .CLK            (CLK),
      .rst            (rst),
      .pix_stb        (pix_stb),
      .i_vram_data    (vram_data),
      .o_address_vram (addr),
      .o_hs           (hs),
      .o_vs           (vs),
      .o_blank        (blank),
      .o_r            (r),
      .o_g            (g),
      .o_b            (b),
      .o_screenend    (se)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) vram_data <= addr[11:0];

   typedef struct {
      int v;
      int h;
      int hs;
      int vs;
      int blank;
      int rgb;
   } exp_t;

   typedef struct {
      int v;
      int h;
      int ca;
      int a;
      int cc;
      int c;
   } spot_t;

   typedef struct {
      int v;
      int h;
      int rb;
      int ad;
      int n;
      int pulses;
      int vslow;
   } seg_t;

   exp_t  sbq[$];
   exp_t  last_e;
   spot_t spots[10];
   int    hits[10];
   seg_t  segs[5];

   int mv = 0, mh = 0, exp_addr = 0;
   int pulse_cnt = 0, vslow_cnt = 0;
   logic [9:0]  jv, jh;
   logic [15:0] jrb, jad;

   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at v=%0d h=%0d: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, mv, mh, act, act, expv, expv);
      end
   endtask

   function automatic int in_win(input int v, input int h);
      return (v >= 60 && v < 420 && h < 640) ? 1 : 0;
   endfunction

   function automatic int ref_addr(input int v, input int h);
      return ((v - 60) / 2) * 320 + h / 2;
   endfunction

   task automatic chk_reset_state();
      chk("rst_hs", hs, 1);
      chk("rst_vs", vs, 1);
      chk("rst_blank", blank, 1);
      chk("rst_rgb", {r, g, b}, 0);
      chk("rst_addr", addr, 0);
      chk("rst_screenend", se, 0);
   endtask

   // One pixel period: a single-CLK strobe followed by PIX_DIV-1 idle clocks.
   task automatic pixel();
      exp_t e;
      e.v     = mv;
      e.h     = mh;
      e.hs    = (mh >= 656 && mh < 752) ? 0 : 1;
      e.vs    = (mv >= 490 && mv < 492) ? 0 : 1;
      e.blank = (mh < 640 && mv < 480) ? 0 : 1;
      if (e.blank == 1)        e.rgb = 0;
      else if (in_win(mv, mh) == 1) e.rgb = ref_addr(mv, mh) & 'hFFF;
      else                     e.rgb = int'(BORDER);
      sbq.push_back(e);
      if (se === 1'b1) pulse_cnt++;
      pix_stb = 1'b1;
      @(posedge CLK);
      #1;
      pix_stb = 1'b0;
      mh = mh + 1;
      if (mh == 800) begin
         mh = 0;
         mv = (mv == 524) ? 0 : mv + 1;
      end
      if (in_win(mv, mh) == 1) exp_addr = ref_addr(mv, mh);
      chk("addr", addr, exp_addr);
      chk("addr_range", (addr > 16'd57599) ? 1 : 0, 0);
      chk("screenend", se, (mh == 639 && mv == 479) ? 1 : 0);
      if (!vs) vslow_cnt++;
      for (int i = 0; i < 10; i++) begin
         if (spots[i].ca == 1 && spots[i].v == mv && spots[i].h == mh) begin
            hits[i]++;
            chk("spot_addr", addr, spots[i].a);
         end
      end
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sbq.pop_front();
         last_e = e;
         chk("hs", hs, e.hs);
         chk("vs", vs, e.vs);
         chk("blank", blank, e.blank);
         chk("rgb", {r, g, b}, e.rgb);
         for (int i = 0; i < 10; i++) begin
            if (spots[i].cc == 1 && spots[i].v == e.v && spots[i].h == e.h) begin
               hits[i]++;
               chk("spot_rgb", {r, g, b}, spots[i].c);
            end
         end
      end
      repeat (PIX_DIV - 1) @(posedge CLK);
      #1;
   endtask

   // Moves the counters (and optionally row base / address) to a new position.
   task automatic jump(input int v, input int h, input int rb, input int ad);
      jv  = 10'(v);
      jh  = 10'(h);
      jrb = 16'(rb);
      jad = 16'(ad);
      force dut.u_timing.v_cnt_q = jv;
      force dut.u_timing.h_cnt_q = jh;
      if (rb >= 0) force dut.row_base_q = jrb;
      if (ad >= 0) force dut.addr_q = jad;
      #1;
      release dut.u_timing.v_cnt_q;
      release dut.u_timing.h_cnt_q;
      if (rb >= 0) release dut.row_base_q;
      if (ad >= 0) release dut.addr_q;
      mv = v;
      mh = h;
      if (ad >= 0) exp_addr = ad;
      sbq.delete();
      @(posedge CLK);
      #1;
   endtask

   task automatic stall_check();
      repeat (50) @(posedge CLK);
      #1;
      chk("stall_addr", addr, exp_addr);
      chk("stall_hs", hs, last_e.hs);
      chk("stall_vs", vs, last_e.vs);
      chk("stall_blank", blank, last_e.blank);
      chk("stall_rgb", {r, g, b}, last_e.rgb);
      chk("stall_screenend", se, 0);
   endtask

   initial begin
      int fall1, fall2, hs_width;
      logic hs_prev;

      spots[0] = '{60, 0, 1, 0, 0, 0};
      spots[1] = '{60, 1, 1, 0, 0, 0};
      spots[2] = '{60, 2, 1, 1, 0, 0};
      spots[3] = '{61, 639, 1, 319, 0, 0};
      spots[4] = '{62, 0, 1, 320, 0, 0};
      spots[5] = '{62, 4, 1, 322, 1, 'h142};
      spots[6] = '{419, 639, 1, 57599, 1, 'h0FF};
      spots[7] = '{59, 620, 0, 0, 1, 'hA5C};
      spots[8] = '{420, 10, 0, 0, 1, 'hA5C};
      spots[9] = '{60, 700, 0, 0, 1, 'h000};
      for (int i = 0; i < 10; i++) hits[i] = 0;

      //          v    h    rb     ad   n     pulses vslow
      segs[0] = '{59, 600, 777, -1, 3420, 0, 0};
      segs[1] = '{418, 795, 57280, -1, 1620, 0, 0};
      segs[2] = '{478, 630, -1, -1, 820, 1, 0};
      segs[3] = '{489, 790, -1, -1, 1620, 0, 1600};
      segs[4] = '{524, 790, -1, -1, 20, 0, 0};

      // Power-on reset
      rst = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk_reset_state();
      rst = 1'b0;

      // Reset in the middle of an image line
      jump(100, 295, 6400, 6547);
      repeat (5) pixel();
      rst = 1'b1;
      @(posedge CLK);
      #1;
      rst = 1'b0;
      mv = 0;
      mh = 0;
      exp_addr = 0;
      sbq.delete();
      chk_reset_state();

      // hsync placement and line period, counted in strobes from reset
      fall1 = -1;
      fall2 = -1;
      hs_width = 0;
      hs_prev = hs;
      for (int k = 1; k <= 1460; k++) begin
         pixel();
         if (hs_prev === 1'b1 && hs === 1'b0) begin
            if (fall1 < 0) fall1 = k;
            else if (fall2 < 0) fall2 = k;
         end
         if (k <= 800 && hs === 1'b0) hs_width++;
         hs_prev = hs;
      end
      chk("hs_first_fall", fall1, 657);
      chk("hs_width", hs_width, 96);
      chk("line_period", fall2 - fall1, 800);

      for (int s = 0; s < 5; s++) begin
         jump(segs[s].v, segs[s].h, segs[s].rb, segs[s].ad);
         pulse_cnt = 0;
         vslow_cnt = 0;
         for (int k = 0; k < segs[s].n; k++) begin
            pixel();
            if (mv == 61 && mh == 100) stall_check();
         end
         chk("screenend_pulses", pulse_cnt, segs[s].pulses);
         chk("vs_low_strobes", vslow_cnt, segs[s].vslow);
      end

      for (int i = 0; i < 10; i++) begin
         chk("spot_reached", hits[i], spots[i].ca + spots[i].cc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
